// File: rtl/alu_control_pipe.sv
// ALU control decoder with a one-cycle registered output and an IDLE/BUSY
// tracker that holds off new requests while a multi-cycle M-extension op runs.
module alu_control_pipe #(
  parameter int unsigned OP_W    = 5,
  parameter bit          M_EXT   = 1'b1,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            stall,
  input  logic            flush,
  output logic [OP_W-1:0] op,
  output logic            out_valid,
  output logic            illegal,
  output logic            busy,
  output logic            done
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [4:0]       r_op;
  logic             r_out_valid;
  logic             r_illegal;

  logic [4:0]       w_base;
  logic [4:0]       w_code;
  logic             w_illegal;
  logic             w_is_m;
  logic             w_accept;
  logic [CNT_W-1:0] w_lat_cnt;

  assign busy      = (r_state == StBusy);
  assign done      = busy && (r_cnt == '0);
  assign in_ready  = !stall && !busy;
  assign w_accept  = in_valid && in_ready;
  assign w_lat_cnt = funct3[2] ? DIV_CNT : MUL_CNT;
  assign op        = OP_W'(r_op);
  assign out_valid = r_out_valid;
  assign illegal   = r_illegal;

  // Base funct3 decode shared by R-type (funct7 = 0) and I-type ALU ops.
  always_comb begin
    w_base = OP_ADD;
    unique case (funct3)
      3'b000: w_base = OP_ADD;
      3'b001: w_base = OP_SLL;
      3'b010: w_base = OP_SLT;
      3'b011: w_base = OP_SLTU;
      3'b100: w_base = OP_XOR;
      3'b101: w_base = OP_SRL;
      3'b110: w_base = OP_OR;
      3'b111: w_base = OP_AND;
    endcase
  end

  // Full decode; illegal encodings present ADD and never start a busy period.
  always_comb begin
    w_code    = OP_ADD;
    w_illegal = 1'b0;
    w_is_m    = 1'b0;
    unique case (alu_op)
      2'b00: w_code = OP_ADD;
      2'b01: w_code = OP_SUB;
      2'b10: begin
        unique case ({funct7_5, funct7_0})
          2'b00: w_code = w_base;
          2'b10: begin
            if (funct3 == 3'b000)      w_code = OP_SUB;
            else if (funct3 == 3'b101) w_code = OP_SRA;
            else                       w_illegal = 1'b1;
          end
          2'b01: begin
            if (M_EXT) begin
              w_code = {2'b10, funct3};
              w_is_m = 1'b1;
            end else begin
              w_illegal = 1'b1;
            end
          end
          2'b11: w_illegal = 1'b1;
        endcase
      end
      2'b11: w_code = (funct3 == 3'b101 && funct7_5) ? OP_SRA : w_base;
    endcase
  end

  // FSM next state: load the latency countdown on a legal M op, count down while busy.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept && w_is_m) begin
          w_state_d = StBusy;
          w_cnt_d   = w_lat_cnt;
        end
      end
      StBusy: begin
        if (r_cnt == '0) w_state_d = StIdle;
        else             w_cnt_d   = r_cnt - 1'b1;
      end
    endcase
  end

  // State registers; flush beats stall, stall freezes everything, op only moves on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_op        <= OP_ADD;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (!stall) begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_out_valid <= w_accept;
      r_illegal   <= w_accept && w_illegal;
      if (w_accept) r_op <= w_illegal ? OP_ADD : w_code;
    end
  end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe: decode sweep, MUL/DIV busy timing,
// stall freeze, illegal encodings, flush and asynchronous reset.
module tb_alu_control_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [1:0] alu_op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       funct7_0;
  logic       stall;
  logic       flush;

  logic       in_ready,  nm_in_ready;
  logic [4:0] op,        nm_op;
  logic       out_valid, nm_out_valid;
  logic       illegal,   nm_illegal;
  logic       busy,      nm_busy;
  logic       done,      nm_done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_control_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .funct7_0  (funct7_0),
    .stall     (stall),
    .flush     (flush),
    .op        (op),
    .out_valid (out_valid),
    .illegal   (illegal),
    .busy      (busy),
    .done      (done)
  );

  alu_control_pipe #(.M_EXT(1'b0)) dut_nm (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (nm_in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .funct7_0  (funct7_0),
    .stall     (stall),
    .flush     (flush),
    .op        (nm_op),
    .out_valid (nm_out_valid),
    .illegal   (nm_illegal),
    .busy      (nm_busy),
    .done      (nm_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [2:0] f3,
                       input logic s5, input logic s0);
    in_valid = v;
    alu_op   = a;
    funct3   = f3;
    funct7_5 = s5;
    funct7_0 = s0;
  endtask

  logic [4:0] rtab [8];
  logic [4:0] e_op;
  logic       e_ill;
  int         n_busy;
  int         n_done;

  initial begin
    rtab = '{5'h02, 5'h04, 5'h08, 5'h09, 5'h03, 5'h05, 5'h01, 5'h00};
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);

    // Reset state
    #12;
    chk("rst_op", op, 5'h02);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Decode sweep, one accept per cycle
    for (int a = 0; a < 4; a++) begin
      for (int f = 0; f < 8; f++) begin
        for (int s = 0; s < 2; s++) begin
          drive(1'b1, 2'(a), 3'(f), 1'(s), 1'b0);
          tick();
          e_ill = 1'b0;
          case (a)
            0: e_op = 5'h02;
            1: e_op = 5'h06;
            2: begin
              if (s == 0)      e_op = rtab[f];
              else if (f == 0) e_op = 5'h06;
              else if (f == 5) e_op = 5'h07;
              else begin
                e_op  = 5'h02;
                e_ill = 1'b1;
              end
            end
            default: e_op = (f == 5 && s == 1) ? 5'h07 : rtab[f];
          endcase
          chk($sformatf("sweep_op a%0d f%0d s%0d", a, f, s), op, e_op);
          chk($sformatf("sweep_ill a%0d f%0d s%0d", a, f, s), illegal, e_ill);
          chk($sformatf("sweep_ov a%0d f%0d s%0d", a, f, s), out_valid, 1);
          chk($sformatf("sweep_busy a%0d f%0d s%0d", a, f, s), busy, 0);
        end
      end
    end
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    tick();
    chk("sweep_end_ov", out_valid, 0);
    chk("sweep_end_ill", illegal, 0);
    chk("sweep_end_op_hold", op, 5'h00);

    // MUL: two busy cycles, done in the second, accept again in the third
    drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b1);
    #1;
    chk("mul_ready_before", in_ready, 1);
    tick();
    chk("mul_op", op, 5'h10);
    chk("mul_ov", out_valid, 1);
    chk("mul_busy1", busy, 1);
    chk("mul_done1", done, 0);
    chk("mul_ready1", in_ready, 0);
    chk("nm_mul_illegal", nm_illegal, 1);
    chk("nm_mul_op", nm_op, 5'h02);
    chk("nm_mul_busy", nm_busy, 0);
    chk("nm_mul_ov", nm_out_valid, 1);
    drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0);
    tick();
    chk("mul_busy2", busy, 1);
    chk("mul_done2", done, 1);
    chk("mul_ready2", in_ready, 0);
    chk("mul_ov2", out_valid, 0);
    chk("mul_op_hold", op, 5'h10);
    tick();
    chk("mul_busy3", busy, 0);
    chk("mul_done3", done, 0);
    chk("mul_ready3", in_ready, 1);
    chk("mul_ov3", out_valid, 0);
    tick();
    chk("mul_reaccept_ov", out_valid, 1);
    chk("mul_reaccept_op", op, 5'h02);
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    tick();

    // Stall freezes out_valid/op
    drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0);
    tick();
    chk("stall_pre_op", op, 5'h06);
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    stall = 1'b1;
    #1;
    chk("stall_ready", in_ready, 0);
    tick();
    chk("stall_ov_frozen", out_valid, 1);
    chk("stall_op_frozen", op, 5'h06);
    stall = 1'b0;
    tick();
    chk("stall_ov_release", out_valid, 0);

    // MUL with stall on the done cycle: done re-presents
    drive(1'b1, 2'b10, 3'b001, 1'b0, 1'b1);
    tick();
    chk("mulh_op", op, 5'h11);
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    tick();
    chk("mulh_done", done, 1);
    stall = 1'b1;
    tick();
    chk("mulh_done_frozen", done, 1);
    chk("mulh_busy_frozen", busy, 1);
    stall = 1'b0;
    tick();
    chk("mulh_busy_end", busy, 0);
    chk("mulh_done_end", done, 0);

    // Illegal R-type
    drive(1'b1, 2'b10, 3'b111, 1'b1, 1'b0);
    tick();
    chk("ill_op", op, 5'h02);
    chk("ill_flag", illegal, 1);
    chk("ill_ov", out_valid, 1);
    chk("ill_busy", busy, 0);
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    tick();
    chk("ill_flag_clear", illegal, 0);
    chk("ill_ov_clear", out_valid, 0);

    // DIV with a 3-cycle stall mid-busy
    drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b1);
    tick();
    chk("div_op", op, 5'h14);
    chk("div_ov", out_valid, 1);
    n_busy = busy ? 1 : 0;
    n_done = done ? 1 : 0;
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      stall = (i >= 10 && i < 13);
      tick();
      if (busy) n_busy++;
      if (done) n_done++;
    end
    stall = 1'b0;
    chk("div_busy_cycles", n_busy, 35);
    chk("div_done_count", n_done, 1);
    chk("div_idle_after", busy, 0);

    // Flush mid-DIV
    drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("flush_pre_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_ov", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_op_kept", op, 5'h14);

    // Flush together with stall and in_valid
    drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    chk("flush_stall_busy", busy, 0);
    chk("flush_stall_ov", out_valid, 0);
    chk("flush_stall_ill", illegal, 0);
    chk("flush_stall_op", op, 5'h14);
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    #1;
    chk("flush_stall_ready", in_ready, 1);

    // Flush overrides an accept in IDLE
    drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    chk("flush_acc_ov", out_valid, 0);
    chk("flush_acc_busy", busy, 0);
    chk("flush_acc_op", op, 5'h14);
    flush = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);

    // Async reset mid-BUSY, between clock edges
    drive(1'b1, 2'b10, 3'b101, 1'b0, 1'b1);
    tick();
    chk("arst_pre_op", op, 5'h15);
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    tick();
    tick();
    chk("arst_pre_busy", busy, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ov", out_valid, 0);
    chk("arst_ill", illegal, 0);
    chk("arst_op", op, 5'h02);
    #2;
    reset = 1'b0;
    tick();
    chk("arst_post_ready", in_ready, 1);
    chk("arst_post_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
